pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq.sv | 93 +++++++++
 tb/tb_pc_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// pc_seq: multi-cycle program counter sequencer; define PC_SEQ_RAS_EN to add the return-address stack
module pc_seq #(
   parameter int N         = 32,
   parameter int CPI       = 3,
   parameter int STEP      = 4,
   parameter int RST_VEC   = 0,
   parameter int RAS_DEPTH = 4
)(
   input  logic         i_clk,
   input  logic         i_rst_,
   input  logic         i_readEn,
   input  logic         i_stall,
   input  logic         i_branch,
   input  logic         i_call,
   input  logic         i_ret,
   input  logic [N-1:0] i_target,
   output logic [N-1:0] o_data,
   output logic [N-1:0] o_pc,
   output logic [2:0]   o_phase,
   output logic         o_fetch,
   output logic         o_commit,
   output logic         o_rasFull,
   output logic         o_rasEmpty,
   output logic         o_rasErr
);
   logic [2:0]   phase;
   logic [N-1:0] pc, pc_n, pc_inc;
   logic         commit;
   assign commit     = phase == 3'(CPI - 1);
   assign pc_inc     = pc + N'(STEP);
   assign o_pc       = pc;
   assign o_data     = i_readEn ? pc : 'z;
   assign o_phase    = phase;
   assign o_fetch    = phase == 3'd0;
   assign o_commit   = commit;
`ifdef PC_SEQ_RAS_EN
   localparam int CW = $clog2(RAS_DEPTH + 1);
   logic [N-1:0]  stk [RAS_DEPTH];
   logic [CW-1:0] cnt;
   logic          err, full, empty, push, pop, err_n;
   assign full       = cnt == CW'(RAS_DEPTH);
   assign empty      = cnt == '0;
   assign o_rasFull  = full;
   assign o_rasEmpty = empty;
   assign o_rasErr   = err;
   // commit decode: ret beats call beats branch; a ret with nothing to pop falls back to sequential
   always_comb begin
      pop   = i_ret && !empty;
      push  = i_call && !i_ret;
      err_n = (i_ret && (empty || i_call)) || (push && full);
      pc_n  = pop ? stk[0] : i_ret ? pc_inc : (i_call || i_branch) ? i_target : pc_inc;
   end
   // stack depth and sticky error; a push onto a full stack keeps the depth saturated
   always_ff @(posedge i_clk or negedge i_rst_)
      if (!i_rst_) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (!i_stall && commit) begin
         if (push) cnt <= full ? cnt : cnt + CW'(1);
         else if (pop) cnt <= cnt - CW'(1);
         err <= err | err_n;
      end
   // stack storage, entry 0 is the top; pushing shifts the oldest entry off the bottom
   always_ff @(posedge i_clk)
      if (i_rst_ && !i_stall && commit) begin
         if (push) begin
            stk[0] <= pc_inc;
            for (int i = 1; i < RAS_DEPTH; i++) stk[i] <= stk[i-1];
         end else if (pop) begin
            for (int i = 0; i < RAS_DEPTH - 1; i++) stk[i] <= stk[i+1];
         end
      end
`else
   logic unused_ras;
   assign unused_ras = i_ret | (RAS_DEPTH < 2);
   assign o_rasFull  = 1'b0;
   assign o_rasEmpty = 1'b1;
   assign o_rasErr   = 1'b0;
   // without a stack a call is just a branch and a ret is ignored
   always_comb begin
      pc_n = (i_call || i_branch) ? i_target : pc_inc;
   end
`endif
   // phase counter and PC; the PC only moves on an unstalled commit edge
   always_ff @(posedge i_clk or negedge i_rst_)
      if (!i_rst_) begin
         phase <= '0;
         pc    <= N'(RST_VEC);
      end else if (!i_stall) begin
         phase <= commit ? 3'd0 : phase + 3'd1;
         if (commit) pc <= pc_n;
      end
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: vector table plus scoreboarded instruction sequences for pc_seq
module tb_pc_seq;
   localparam int N = 32;
   logic         i_clk = 1'b0, i_rst_ = 1'b0, i_readEn = 1'b0, i_stall = 1'b0;
   logic         i_branch = 1'b0, i_call = 1'b0, i_ret = 1'b0;
   logic [N-1:0] i_target = '0;
   wire  [N-1:0] o_data;
   logic [N-1:0] o_pc;
   logic [2:0]   o_phase;
   logic         o_fetch, o_commit, o_rasFull, o_rasEmpty, o_rasErr;

   pc_seq #(.N(N), .CPI(3), .STEP(4), .RST_VEC(0), .RAS_DEPTH(4)) dut (
      .i_clk(i_clk), .i_rst_(i_rst_), .i_readEn(i_readEn), .i_stall(i_stall),
      .i_branch(i_branch), .i_call(i_call), .i_ret(i_ret), .i_target(i_target),
      .o_data(o_data), .o_pc(o_pc), .o_phase(o_phase), .o_fetch(o_fetch),
      .o_commit(o_commit), .o_rasFull(o_rasFull), .o_rasEmpty(o_rasEmpty), .o_rasErr(o_rasErr)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic st, br, ca, re, rd;
      logic [N-1:0] tgt;
      logic [N-1:0] pc;
      logic [2:0] ph;
   } vec_t;
   typedef struct {
      logic [N-1:0] pc;
      logic [2:0] ph;
      logic rd;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[19];
   int n_run = 0, n_fail = 0;
   logic [N-1:0] cur_pc;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_flags(input logic full, input logic empty, input logic err);
      chk("rasFull", N'(o_rasFull), N'(full));
      chk("rasEmpty", N'(o_rasEmpty), N'(empty));
      chk("rasErr", N'(o_rasErr), N'(err));
   endtask

   task automatic cyc(input logic st, br, ca, re, rd, input logic [N-1:0] tgt,
                      input logic [N-1:0] epc, input logic [2:0] eph);
      exp_t e;
      i_stall = st; i_branch = br; i_call = ca; i_ret = re; i_readEn = rd; i_target = tgt;
      sb.push_back('{pc: epc, ph: eph, rd: rd});
      @(posedge i_clk);
      #1;
      e = sb.pop_front();
      chk("pc", o_pc, e.pc);
      chk("phase", N'(o_phase), N'(e.ph));
      chk("fetch", N'(o_fetch), N'(e.ph == 3'd0));
      chk("commit", N'(o_commit), N'(e.ph == 3'd2));
      if (e.rd) chk("data", o_data, e.pc);
      else chk("data_hiz", N'(o_data !== e.pc), N'(1'b1));
   endtask

   // controls are held across the whole instruction: they must only matter at the commit edge
   task automatic instr(input logic br, ca, re, input logic [N-1:0] tgt, input logic [N-1:0] epc);
      for (int k = 1; k < 3; k++) cyc(1'b0, br, ca, re, 1'b1, tgt, cur_pc, 3'(k));
      cyc(1'b0, br, ca, re, 1'b1, tgt, epc, 3'd0);
      cur_pc = epc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //            st  br  ca  re  rd  tgt            pc             ph
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h0,   3'd1};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h0,   3'd2};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h4,   3'd0};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h4,   3'd1};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h4,   3'd2};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h8,   3'd0};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h8,   3'd1};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h8,   3'd2};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'hC,   3'd0};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'hC,   3'd1};
      tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 32'h100, 32'hC,   3'd2};
      tbl[11] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 32'h100, 32'h100, 3'd0};
      tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h100, 3'd1};
      tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h100, 3'd2};
      tbl[14] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 32'h300, 32'h100, 3'd2};
      tbl[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 32'h300, 32'h100, 3'd2};
      tbl[16] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 32'h300, 32'h100, 3'd2};
      tbl[17] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 32'h300, 32'h100, 3'd2};
      tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h104, 3'd0};

      #22;
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_phase", N'(o_phase), 32'h0);
      chk("rst_fetch", N'(o_fetch), 32'h1);
      chk("rst_commit", N'(o_commit), 32'h0);
      chk_flags(1'b0, 1'b1, 1'b0);
      #1 i_rst_ = 1'b1;

      foreach (tbl[i])
         cyc(tbl[i].st, tbl[i].br, tbl[i].ca, tbl[i].re, tbl[i].rd, tbl[i].tgt, tbl[i].pc, tbl[i].ph);
      cur_pc = 32'h104;

`ifdef PC_SEQ_RAS_EN
      instr(1'b1, 1'b0, 1'b0, 32'h20, 32'h20);
      instr(1'b0, 1'b1, 1'b0, 32'h200, 32'h200);
      chk_flags(1'b0, 1'b0, 1'b0);
      instr(1'b0, 1'b0, 1'b1, 32'h0, 32'h24);
      chk_flags(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         instr(1'b0, 1'b1, 1'b0, 32'(i) << 12, 32'(i) << 12);
         if (i == 4) chk_flags(1'b1, 1'b0, 1'b0);
      end
      chk_flags(1'b1, 1'b0, 1'b1);
      instr(1'b0, 1'b1, 1'b1, 32'h9000, 32'h4004);
      chk_flags(1'b0, 1'b0, 1'b1);
      instr(1'b0, 1'b0, 1'b1, 32'h0, 32'h3004);
      instr(1'b0, 1'b0, 1'b1, 32'h0, 32'h2004);
      instr(1'b0, 1'b0, 1'b1, 32'h0, 32'h1004);
      chk_flags(1'b0, 1'b1, 1'b1);
      instr(1'b0, 1'b0, 1'b1, 32'h0, 32'h1008);
      chk_flags(1'b0, 1'b1, 1'b1);
`else
      instr(1'b0, 1'b0, 1'b1, 32'h0, cur_pc + 32'h4);
      chk_flags(1'b0, 1'b1, 1'b0);
      instr(1'b0, 1'b1, 1'b0, 32'h700, 32'h700);
      chk_flags(1'b0, 1'b1, 1'b0);
`endif

      instr(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h4);

      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 3'd1);
      #2 i_rst_ = 1'b0;
      #1;
      chk("async_pc", o_pc, 32'h0);
      chk("async_phase", N'(o_phase), 32'h0);
      chk("async_fetch", N'(o_fetch), 32'h1);
      chk("async_commit", N'(o_commit), 32'h0);
      chk_flags(1'b0, 1'b1, 1'b0);
      #2 i_rst_ = 1'b1;
      cur_pc = 32'h0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'd2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 3'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
